// File: rtl/waveform_pkg.sv
// Shared types and width helpers for the waveform trigger block.
package waveform_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEEK_LOW  = 2'd1,
    ST_SEEK_HIGH = 2'd2,
    ST_CAPTURE   = 2'd3
  } wt_state_e;

  // LSB position of the left-justified mono sample inside a FIFO word.
  function automatic int sample_lsb(input int data_width, input int sample_width);
    return data_width - sample_width;
  endfunction

  // Column counter width; a 1-column capture still needs a 1-bit counter.
  function automatic int col_cnt_width(input int num_columns);
    return (num_columns > 1) ? $clog2(num_columns) : 1;
  endfunction

  // Timeout counter must be able to hold TIMEOUT_SAMPLES itself.
  function automatic int to_cnt_width(input int timeout_samples);
    return $clog2(timeout_samples + 1);
  endfunction

endpackage

// File: rtl/waveform_trigger_if.sv
// FIFO read side plus sample stream towards sample_to_pixel.
interface waveform_trigger_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24
);
  logic [DATA_WIDTH-1:0]          fifo_dout;
  logic                           fifo_empty;
  logic                           fifo_rd_en;
  logic signed [SAMPLE_WIDTH-1:0] out_sample;
  logic                           out_valid;
  logic                           out_ready;
  logic                           out_last;

  // Trigger block's view.
  modport slave (
    input  fifo_dout, fifo_empty, out_ready,
    output fifo_rd_en, out_sample, out_valid, out_last
  );

  // FIFO / consumer view.
  modport master (
    output fifo_dout, fifo_empty, out_ready,
    input  fifo_rd_en, out_sample, out_valid, out_last
  );
endinterface

// File: rtl/waveform_trigger_reader.sv
// Non-FWFT FIFO read engine: one read in flight, sample handed over the
// cycle after the strobe. Issues a read only when the consumer has room.
module trigger_fifo_reader
  import waveform_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic                           slot_free,
  input  logic                           fifo_empty,
  input  logic [DATA_WIDTH-1:0]          fifo_dout,
  output logic                           fifo_rd_en,
  output logic                           smp_valid,
  output logic signed [SAMPLE_WIDTH-1:0] smp_data
);
  localparam int LSB = sample_lsb(DATA_WIDTH, SAMPLE_WIDTH);

  logic rd_pend;
  logic unused_dout;

  assign fifo_rd_en  = resetn && enable && !fifo_empty && !rd_pend && slot_free;
  assign smp_valid   = rd_pend;
  assign smp_data    = fifo_dout[LSB +: SAMPLE_WIDTH];
  assign unused_dout = ^fifo_dout;

  // Marks the cycle in which the FIFO presents the word just requested.
  always_ff @(posedge clk) begin
    if (!resetn) rd_pend <= 1'b0;
    else         rd_pend <= fifo_rd_en;
  end
endmodule

// File: rtl/waveform_trigger.sv
// Per-frame rising zero-crossing trigger with hysteresis and auto-trigger.
//
// state        | meaning
// ST_IDLE      | waiting for frame_pulse, no FIFO reads
// ST_SEEK_LOW  | discarding samples until one falls below -HYST
// ST_SEEK_HIGH | discarding samples until one reaches +HYST
// ST_CAPTURE   | forwarding NUM_COLUMNS samples through the output register
module waveform_trigger
  import waveform_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int SAMPLE_WIDTH    = 24,
  parameter int NUM_COLUMNS     = 640,
  parameter int HYST            = 4096,
  parameter int TIMEOUT_SAMPLES = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_pulse,
  waveform_trigger_if.slave bus,
  output logic              triggered
);
  localparam int CW = col_cnt_width(NUM_COLUMNS);
  localparam int TW = to_cnt_width(TIMEOUT_SAMPLES);
  localparam logic signed [SAMPLE_WIDTH-1:0] HYST_POS = SAMPLE_WIDTH'(HYST);
  localparam logic signed [SAMPLE_WIDTH-1:0] HYST_NEG = -HYST_POS;
  localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLUMNS - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_SAMPLES);

  wt_state_e                      state, state_nxt;
  logic [TW-1:0]                  to_cnt, to_nxt;
  logic [CW-1:0]                  col_cnt, col_nxt;
  logic signed [SAMPLE_WIDTH-1:0] smp_q, smp_nxt;
  logic                           vld_q, vld_nxt;
  logic                           trig_q, trig_nxt;
  logic                           hs, last, slot_free, load, load_trig;
  logic                           smp_valid;
  logic signed [SAMPLE_WIDTH-1:0] smp_data;

  assign hs   = vld_q && bus.out_ready;
  assign last = vld_q && (col_cnt == COL_LAST);
  // Seeking discards immediately; capture needs the output register free
  // and must not fetch past the final column.
  assign slot_free = (state != ST_CAPTURE) || ((!vld_q || hs) && !last);

  trigger_fifo_reader #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_reader (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (state != ST_IDLE),
    .slot_free (slot_free),
    .fifo_empty(bus.fifo_empty),
    .fifo_dout (bus.fifo_dout),
    .fifo_rd_en(bus.fifo_rd_en),
    .smp_valid (smp_valid),
    .smp_data  (smp_data)
  );

  assign bus.out_sample = smp_q;
  assign bus.out_valid  = vld_q;
  assign bus.out_last   = last;
  assign triggered      = trig_q;

  // Next-state and datapath decisions; a consumed sample either advances the
  // seek or becomes column 0.
  always_comb begin
    state_nxt = state;
    to_nxt    = to_cnt;
    col_nxt   = col_cnt;
    smp_nxt   = smp_q;
    vld_nxt   = vld_q;
    trig_nxt  = trig_q;
    load      = 1'b0;
    load_trig = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (frame_pulse) begin
          state_nxt = ST_SEEK_LOW;
          to_nxt    = '0;
        end
      end
      ST_SEEK_LOW: begin
        if (smp_valid) begin
          if (to_cnt == TO_LIMIT) begin
            load = 1'b1;
          end else begin
            if (smp_data < HYST_NEG) state_nxt = ST_SEEK_HIGH;
            to_nxt = to_cnt + TW'(1);
          end
        end
      end
      ST_SEEK_HIGH: begin
        if (smp_valid) begin
          if (smp_data >= HYST_POS) begin
            load      = 1'b1;
            load_trig = 1'b1;
          end else if (to_cnt == TO_LIMIT) begin
            load = 1'b1;
          end else begin
            to_nxt = to_cnt + TW'(1);
          end
        end
      end
      ST_CAPTURE: begin
        if (hs) begin
          vld_nxt = 1'b0;
          col_nxt = col_cnt + CW'(1);
          if (last) begin
            state_nxt = ST_IDLE;
            col_nxt   = '0;
          end
        end
        if (smp_valid) begin
          smp_nxt = smp_data;
          vld_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (load) begin
      state_nxt = ST_CAPTURE;
      smp_nxt   = smp_data;
      vld_nxt   = 1'b1;
      col_nxt   = '0;
      trig_nxt  = load_trig;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      to_cnt  <= '0;
      col_cnt <= '0;
      smp_q   <= '0;
      vld_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      to_cnt  <= to_nxt;
      col_cnt <= col_nxt;
      smp_q   <= smp_nxt;
      vld_q   <= vld_nxt;
      trig_q  <= trig_nxt;
    end
  end
endmodule

// File: tb/tb_waveform_trigger.sv
// Bench for waveform_trigger: FIFO model, reference trigger search, stream checks.
module tb_waveform_trigger;
  localparam int NC    = 640;
  localparam int HY    = 4096;
  localparam int TO    = 4096;
  localparam int SRC_N = 65536;

  logic clk = 1'b0;
  logic resetn;
  logic frame_pulse;
  logic triggered;

  waveform_trigger_if #(.DATA_WIDTH(32), .SAMPLE_WIDTH(24)) bus ();

  waveform_trigger #(
    .DATA_WIDTH(32), .SAMPLE_WIDTH(24), .NUM_COLUMNS(NC),
    .HYST(HY), .TIMEOUT_SAMPLES(TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_pulse(frame_pulse),
    .bus        (bus),
    .triggered  (triggered)
  );

  always #5 clk = ~clk;

  // FIFO model: src[] holds the sample stream, rd_ptr is the next word to pop.
  logic signed [23:0] src [0:SRC_N-1];
  int rd_ptr = 0;
  int avail  = 0;
  bit gap    = 1'b0;

  assign bus.fifo_empty = gap || (rd_ptr >= avail);

  always @(posedge clk) begin
    if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_dout <= {src[rd_ptr], 8'($urandom)};
      rd_ptr        <= rd_ptr + 1;
    end
  end

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  int exp_col0 = 0;
  int ncols    = 0;
  bit cap_on   = 1'b0;
  bit saw_last = 1'b0;
  bit hold_prev = 1'b0;
  logic [31:0] hold_smp;
  logic        hold_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference search: walk the stream with the trigger rules directly.
  task automatic model_start(input int b, output int col0, output bit trig);
    bit armed;
    int n;
    armed = 1'b0;
    n     = 0;
    col0  = -1;
    trig  = 1'b0;
    for (int i = b; i < SRC_N; i++) begin
      int s;
      s = int'(src[i]);
      if (armed && s >= HY) begin col0 = i; trig = 1'b1; break; end
      if (n == TO) begin col0 = i; trig = 1'b0; break; end
      if (!armed && s < -HY) armed = 1'b1;
      n++;
    end
  endtask

  // One clock: check the cycle's outputs, then advance to the next negedge.
  task automatic cyc();
    #1;
    chk("no_rd_when_empty", 32'(!(bus.fifo_rd_en && bus.fifo_empty)), 32'd1);
    if (hold_prev) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_sample", 32'(bus.out_sample), hold_smp);
      chk("hold_last", 32'(bus.out_last), 32'(hold_last));
    end
    if (bus.out_last) saw_last = 1'b1;
    if (bus.out_valid && bus.out_ready) begin
      if (cap_on) begin
        chk("col_sample", 32'(bus.out_sample), 32'(src[exp_col0 + ncols]));
        chk("col_last", 32'(bus.out_last), 32'(ncols == NC - 1));
      end
      ncols++;
    end
    hold_prev = resetn && bus.out_valid && !bus.out_ready;
    hold_smp  = 32'(bus.out_sample);
    hold_last = bus.out_last;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic set_ready(input int mode);
    case (mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = (cyc_n % 4 == 0);
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic load_sine(input int n, input real amp, input int period);
    for (int k = 0; k < n; k++)
      src[rd_ptr + k] = 24'($rtoi(amp * $sin(6.283185307179586 * real'(k) / real'(period))));
    avail = rd_ptr + n;
  endtask

  // Start a frame and follow one capture; optional mid-capture frame_pulse
  // and a FIFO outage once gap_at samples of this frame have been consumed.
  task automatic run_capture(input int mode, input int pulse_col, input int gap_at);
    int  col0, base, budget, gap_cnt;
    bit  trig, pulsed, gap_done;
    base = rd_ptr;
    model_start(base, col0, trig);
    exp_col0 = col0; ncols = 0; cap_on = 1'b1; hold_prev = 1'b0;
    pulsed = 1'b0; gap_done = 1'b0; gap_cnt = 0; budget = 30000;
    bus.out_ready = 1'b1;
    frame_pulse = 1'b1;
    cyc();
    frame_pulse = 1'b0;
    while (ncols < NC && budget > 0) begin
      set_ready(mode);
      frame_pulse = (ncols == pulse_col) && !pulsed;
      if (frame_pulse) pulsed = 1'b1;
      if (gap_at >= 0 && !gap_done && (rd_ptr - base) >= gap_at) begin
        gap = 1'b1;
        gap_cnt++;
        if (gap_cnt > 1000) begin gap = 1'b0; gap_done = 1'b1; end
      end
      cyc();
      budget--;
    end
    frame_pulse = 1'b0;
    gap = 1'b0;
    chk("col_count", 32'(ncols), 32'(NC));
    chk("triggered", 32'(triggered), 32'(trig));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_no_rd", 32'(bus.fifo_rd_en), 32'd0);
    end
    chk("no_extra_cols", 32'(ncols), 32'(NC));
    cap_on = 1'b0;
  endtask

  initial begin
    int amp, per;
    resetn = 1'b0; frame_pulse = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_sample", 32'(bus.out_sample), 32'd0);
    chk("rst_trig", 32'(triggered), 32'd0);
    chk("rst_rd", 32'(bus.fifo_rd_en), 32'd0);
    resetn = 1'b1;

    // Data present but no frame yet: must stay idle.
    load_sine(1000, 100000.0, 100);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_before_frame", 32'(bus.fifo_rd_en), 32'd0);
    end

    // Sine, no backpressure.
    run_capture(0, -1, -1);

    // Constant zero: auto-trigger after TIMEOUT discarded samples.
    for (int k = 0; k < 5000; k++) src[rd_ptr + k] = '0;
    avail = rd_ptr + 5000;
    run_capture(0, -1, -1);

    // Sine with ready high one cycle in four.
    load_sine(1000, 100000.0, 100);
    run_capture(1, -1, -1);

    // Hysteresis boundaries: -4096 and 4095 must not count, -4097 and 4096 do.
    src[rd_ptr + 0] = -24'sd4096;
    src[rd_ptr + 1] = 24'sd5000;
    src[rd_ptr + 2] = -24'sd4097;
    src[rd_ptr + 3] = 24'sd4095;
    src[rd_ptr + 4] = 24'sd4096;
    for (int k = 5; k < 800; k++) src[rd_ptr + k] = 24'($urandom_range(0, 16000)) - 24'sd8000;
    avail = rd_ptr + 800;
    run_capture(2, -1, -1);

    // Outage mid-SEEK_HIGH: 1000 empty cycles, trigger well before the
    // timeout counted in samples but after it if cycles were counted.
    src[rd_ptr] = -24'sd5000;
    for (int k = 1; k < 4050; k++) src[rd_ptr + k] = '0;
    src[rd_ptr + 4050] = 24'sd5000;
    for (int k = 4051; k < 4800; k++) src[rd_ptr + k] = 24'($urandom_range(0, 2000));
    avail = rd_ptr + 4800;
    run_capture(0, -1, 2000);

    // frame_pulse at column 300 is ignored.
    load_sine(1000, 100000.0, 100);
    run_capture(0, 300, -1);

    // Random noise and random sine with random backpressure.
    for (int k = 0; k < 5000; k++) src[rd_ptr + k] = 24'($urandom_range(0, 20000)) - 24'sd10000;
    avail = rd_ptr + 5000;
    run_capture(2, -1, -1);
    amp = int'($urandom_range(5000, 500000));
    per = int'($urandom_range(20, 400));
    load_sine(2000, real'(amp), per);
    run_capture(2, -1, -1);

    // Reset at column 200 abandons the capture.
    load_sine(1000, 100000.0, 100);
    begin
      int col0, budget;
      bit trig;
      model_start(rd_ptr, col0, trig);
      exp_col0 = col0; ncols = 0; cap_on = 1'b1; hold_prev = 1'b0; budget = 5000;
      bus.out_ready = 1'b1;
      frame_pulse = 1'b1;
      cyc();
      frame_pulse = 1'b0;
      while (ncols < 200 && budget > 0) begin cyc(); budget--; end
      chk("pre_reset_cols", 32'(ncols), 32'd200);
      cap_on = 1'b0;
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_last", 32'(bus.out_last), 32'd0);
      chk("mid_rst_sample", 32'(bus.out_sample), 32'd0);
      chk("mid_rst_trig", 32'(triggered), 32'd0);
      chk("mid_rst_rd", 32'(bus.fifo_rd_en), 32'd0);
      saw_last = 1'b0;
      for (int i = 0; i < 30; i++) cyc();
      chk("no_partial_last", 32'(saw_last), 32'd0);
    end
    load_sine(1000, 100000.0, 100);
    run_capture(0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
